// File: rtl/serial_crc_ccitt_dual.sv
// serial_crc_ccitt_dual: dual bit-serial CRC-16-CCITT LFSR (per-bit and vector styles); `CRC_CHECK_EN adds crc_ok/crc_mismatch
module serial_crc_ccitt_dual #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        init,
  input  logic        data_in,
  output logic [15:0] bad,
  output logic [15:0] good
`ifdef CRC_CHECK_EN
  ,
  output logic        crc_ok,
  output logic        crc_mismatch
`endif
);
  logic [15:0] r_bad;
  logic [15:0] r_good;
  logic        w_fb_bad;
  logic        w_fb_good;
  assign w_fb_bad  = data_in ^ r_bad[15];
  assign w_fb_good = data_in ^ r_good[15];
  assign bad  = r_bad;
  assign good = r_good;
  // legacy copy: each register bit shifts from its neighbour and picks up feedback where POLY has a tap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_bad <= SEED;
    else if (enable && init) r_bad <= SEED;
    else if (enable) begin
      r_bad[0]  <= w_fb_bad & POLY[0];
      r_bad[1]  <= r_bad[0]  ^ (w_fb_bad & POLY[1]);
      r_bad[2]  <= r_bad[1]  ^ (w_fb_bad & POLY[2]);
      r_bad[3]  <= r_bad[2]  ^ (w_fb_bad & POLY[3]);
      r_bad[4]  <= r_bad[3]  ^ (w_fb_bad & POLY[4]);
      r_bad[5]  <= r_bad[4]  ^ (w_fb_bad & POLY[5]);
      r_bad[6]  <= r_bad[5]  ^ (w_fb_bad & POLY[6]);
      r_bad[7]  <= r_bad[6]  ^ (w_fb_bad & POLY[7]);
      r_bad[8]  <= r_bad[7]  ^ (w_fb_bad & POLY[8]);
      r_bad[9]  <= r_bad[8]  ^ (w_fb_bad & POLY[9]);
      r_bad[10] <= r_bad[9]  ^ (w_fb_bad & POLY[10]);
      r_bad[11] <= r_bad[10] ^ (w_fb_bad & POLY[11]);
      r_bad[12] <= r_bad[11] ^ (w_fb_bad & POLY[12]);
      r_bad[13] <= r_bad[12] ^ (w_fb_bad & POLY[13]);
      r_bad[14] <= r_bad[13] ^ (w_fb_bad & POLY[14]);
      r_bad[15] <= r_bad[14] ^ (w_fb_bad & POLY[15]);
    end
  end
  // corrected copy: whole-vector shift with POLY xored in when feedback is set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_good <= SEED;
    else if (enable && init) r_good <= SEED;
    else if (enable) r_good <= {r_good[14:0], 1'b0} ^ (w_fb_good ? POLY : 16'h0000);
  end
`ifdef CRC_CHECK_EN
  logic r_crc_ok;
  logic r_crc_mismatch;
  assign crc_ok       = r_crc_ok;
  assign crc_mismatch = r_crc_mismatch;
  // residue flag trails good by one cycle; mismatch is sticky until reset or reseed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc_ok       <= 1'b0;
      r_crc_mismatch <= 1'b0;
    end else begin
      r_crc_ok       <= (r_good == 16'h0000);
      r_crc_mismatch <= (enable && init) ? 1'b0 : (r_crc_mismatch | (r_bad != r_good));
    end
  end
`endif
endmodule

// File: tb/tb_serial_crc_ccitt_dual.sv
// tb_serial_crc_ccitt_dual: directed and random checks of the dual CRC-16-CCITT LFSR
module tb_serial_crc_ccitt_dual;
  logic        clk;
  logic        reset;
  logic        enable;
  logic        init;
  logic        data_in;
  logic [15:0] bad;
  logic [15:0] good;
  int          n_tests;
  int          n_fail;
`ifdef CRC_CHECK_EN
  logic        crc_ok;
  logic        crc_mismatch;
`endif

  serial_crc_ccitt_dual dut (
    .clk(clk), .reset(reset), .enable(enable), .init(init), .data_in(data_in),
    .bad(bad), .good(good)
`ifdef CRC_CHECK_EN
    , .crc_ok(crc_ok), .crc_mismatch(crc_mismatch)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    return {c[14:0], 1'b0} ^ ((d ^ c[15]) ? 16'h1021 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    enable = 1; init = 0; data_in = b;
    tick();
  endtask

  task automatic reseed();
    enable = 1; init = 1; data_in = 0;
    tick();
    init = 0;
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; init = 0; data_in = 0;
    tick();
    n_tests++; if (bad !== 16'hFFFF) begin n_fail++; $display("FAIL reset_bad got %h want ffff", bad); end
    n_tests++; if (good !== 16'hFFFF) begin n_fail++; $display("FAIL reset_good got %h want ffff", good); end
    reset = 0;
    send_bit(0); send_bit(1); send_bit(0);
    @(negedge clk);
    reset = 1;
    #1;
    n_tests++; if (bad !== 16'hFFFF) begin n_fail++; $display("FAIL async_reset_bad got %h want ffff", bad); end
    n_tests++; if (good !== 16'hFFFF) begin n_fail++; $display("FAIL async_reset_good got %h want ffff", good); end
    tick();
    reset = 0;
    enable = 0;
  endtask

  task automatic test_one_bit();
    send_bit(0);
    n_tests++; if (bad !== 16'hEFDF) begin n_fail++; $display("FAIL bit0_bad got %h want efdf", bad); end
    n_tests++; if (good !== 16'hEFDF) begin n_fail++; $display("FAIL bit0_good got %h want efdf", good); end
    reseed();
    send_bit(1);
    n_tests++; if (bad !== 16'hFFFE) begin n_fail++; $display("FAIL bit1_bad got %h want fffe", bad); end
    n_tests++; if (good !== 16'hFFFE) begin n_fail++; $display("FAIL bit1_good got %h want fffe", good); end
  endtask

  task automatic test_check_string();
    logic [7:0] msg [9];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    reseed();
    for (int i = 0; i < 9; i++)
      for (int b = 7; b >= 0; b--) send_bit(msg[i][b]);
    n_tests++; if (bad !== 16'h29B1) begin n_fail++; $display("FAIL check_bad got %h want 29b1", bad); end
    n_tests++; if (good !== 16'h29B1) begin n_fail++; $display("FAIL check_good got %h want 29b1", good); end
  endtask

  task automatic test_residue();
    logic [15:0] crc;
    crc = 16'h29B1;
    for (int b = 15; b >= 0; b--) send_bit(crc[b]);
    n_tests++; if (bad !== 16'h0000) begin n_fail++; $display("FAIL residue_bad got %h want 0000", bad); end
    n_tests++; if (good !== 16'h0000) begin n_fail++; $display("FAIL residue_good got %h want 0000", good); end
    enable = 0;
    tick();
`ifdef CRC_CHECK_EN
    n_tests++; if (crc_ok !== 1'b1) begin n_fail++; $display("FAIL crc_ok got %b want 1", crc_ok); end
`endif
  endtask

  task automatic test_hold();
    reseed();
    send_bit(0);
    for (int i = 0; i < 5; i++) begin
      enable = 0; init = 1'($urandom_range(1)); data_in = 1'($urandom_range(1));
      tick();
      n_tests++; if (bad !== 16'hEFDF) begin n_fail++; $display("FAIL hold_bad[%0d] got %h want efdf", i, bad); end
      n_tests++; if (good !== 16'hEFDF) begin n_fail++; $display("FAIL hold_good[%0d] got %h want efdf", i, good); end
    end
  endtask

  task automatic test_init();
    enable = 1; init = 1; data_in = 1;
    tick();
    n_tests++; if (bad !== 16'hFFFF) begin n_fail++; $display("FAIL init_bad got %h want ffff", bad); end
    n_tests++; if (good !== 16'hFFFF) begin n_fail++; $display("FAIL init_good got %h want ffff", good); end
    init = 0; enable = 0;
  endtask

  task automatic test_random();
    logic [15:0] model;
    int          shown;
    model = good;
    shown = 0;
    for (int i = 0; i < 10000; i++) begin
      reset   = ($urandom_range(63) == 0);
      init    = ($urandom_range(63) == 0);
      enable  = 1'($urandom_range(1));
      data_in = 1'($urandom_range(1));
      tick();
      if (reset) model = 16'hFFFF;
      else if (enable && init) model = 16'hFFFF;
      else if (enable) model = crc_step(model, data_in);
      n_tests++;
      if (bad !== good || good !== model) begin
        n_fail++;
        if (shown < 10) $display("FAIL random[%0d] bad %h good %h want %h", i, bad, good, model);
        shown++;
      end
    end
    reset = 0; enable = 0; init = 0;
`ifdef CRC_CHECK_EN
    tick();
    n_tests++; if (crc_mismatch !== 1'b0) begin n_fail++; $display("FAIL crc_mismatch got %b want 0", crc_mismatch); end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_one_bit();
    test_check_string();
    test_residue();
    test_hold();
    test_init();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
